// File: rtl/hls_deadlock_report_arbiter.sv
// Purpose: debounce HLS deadlock-monitor block bits, latch confirmed deadlocks, report them round-robin.
// Latency: pending is set PERSIST cycles after block rises; report_valid follows one cycle after pending.
// Backpressure: report holds id/time until report_ready; optional stamps via HLS_DEADLOCK_TIMESTAMP_EN.
module hls_deadlock_report_arbiter #(
    parameter int NUM_MON = 4,
    parameter int ID_W    = 2,
    parameter int PERSIST = 16,
    parameter int CNT_W   = 8,
    parameter int TS_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_MON-1:0] mon_block,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [ID_W-1:0]    report_id,
    output logic [TS_W-1:0]    report_time,
    output logic [NUM_MON-1:0] pending,
    output logic               deadlock_seen,
    input  logic               clear_seen
);

    typedef enum logic {
        IDLE   = 1'b0,
        REPORT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] PERSIST_C  = CNT_W'(PERSIST);
    localparam logic [CNT_W-1:0] CONFIRM_AT = CNT_W'(PERSIST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q [NUM_MON];
    logic [NUM_MON-1:0] armed_q;
    logic [NUM_MON-1:0] confirm;
    logic [NUM_MON-1:0] done_mask;
    logic [ID_W-1:0]    last_grant_q;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    hi_id;
    logic [ID_W-1:0]    lo_id;
    logic               hi_found;
    logic               lo_found;
    logic               grant_load;
    logic               xfer;

    // Persistence counters saturate so a long block never wraps back into a confirm.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_MON; i++) begin
            if (reset || !enable || !mon_block[i]) begin
                cnt_q[i] <= '0;
            end else if (cnt_q[i] != PERSIST_C) begin
                cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_comb begin
        confirm = '0;
        for (int i = 0; i < NUM_MON; i++) begin
            confirm[i] = enable && mon_block[i] && armed_q[i] && (cnt_q[i] == CONFIRM_AT);
        end
    end

    // Round-robin: lowest pending index above last_grant, else wrap to lowest pending index.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (pending[i]) begin
                if (ID_W'(i) > last_grant_q) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end
                lo_found = 1'b1;
                lo_id    = ID_W'(i);
            end
        end
        grant_id = hi_found ? hi_id : lo_id;
    end

    always_comb begin
        state_d      = state_q;
        report_valid = 1'b0;
        xfer         = 1'b0;
        grant_load   = 1'b0;
        done_mask    = '0;
        case (state_q)
            IDLE: begin
                if (lo_found) begin
                    grant_load = 1'b1;
                    state_d    = REPORT;
                end
            end
            REPORT: begin
                report_valid = 1'b1;
                if (report_ready) begin
                    xfer      = 1'b1;
                    done_mask = NUM_MON'(1) << report_id;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            pending       <= '0;
            armed_q       <= '1;
            last_grant_q  <= ID_W'(NUM_MON - 1);
            report_id     <= '0;
            deadlock_seen <= 1'b0;
        end else begin
            state_q <= state_d;
            pending <= (pending | confirm) & ~done_mask;
            // Re-arm only once the deadlock has been reported and the block has dropped.
            armed_q <= (armed_q & ~confirm) | (~pending & ~mon_block);
            if (grant_load) begin
                report_id <= grant_id;
            end
            if (xfer) begin
                last_grant_q <= report_id;
            end
            if (|confirm) begin
                deadlock_seen <= 1'b1;
            end else if (clear_seen) begin
                deadlock_seen <= 1'b0;
            end
        end
    end

`ifdef HLS_DEADLOCK_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] stamp_q [NUM_MON];

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt_q    <= '0;
            report_time <= '0;
            for (int i = 0; i < NUM_MON; i++) begin
                stamp_q[i] <= '0;
            end
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
            for (int i = 0; i < NUM_MON; i++) begin
                if (confirm[i]) begin
                    stamp_q[i] <= ts_cnt_q;
                end
            end
            if (grant_load) begin
                report_time <= stamp_q[grant_id];
            end
        end
    end
`else
    assign report_time = '0;
`endif

endmodule

// File: tb/tb_hls_deadlock_report_arbiter.sv
// Bench for hls_deadlock_report_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_hls_deadlock_report_arbiter;
    localparam int N       = 4;
    localparam int ID_W    = 2;
    localparam int PERSIST = 16;
    localparam int CNT_W   = 8;
    localparam int TS_W    = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic [N-1:0]    mon_block = '0;
    logic            report_ready = 1'b0;
    logic            clear_seen = 1'b0;
    logic            report_valid;
    logic [ID_W-1:0] report_id;
    logic [TS_W-1:0] report_time;
    logic [N-1:0]    pending;
    logic            deadlock_seen;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    hls_deadlock_report_arbiter #(
        .NUM_MON(N), .ID_W(ID_W), .PERSIST(PERSIST), .CNT_W(CNT_W), .TS_W(TS_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .mon_block(mon_block),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_id(report_id),
        .report_time(report_time),
        .pending(pending),
        .deadlock_seen(deadlock_seen),
        .clear_seen(clear_seen)
    );

    // Behavioural model: run = consecutive enabled-high cycles seen so far.
    int            run [N];
    bit            m_armed [N];
    bit [TS_W-1:0] m_stamp [N];
    bit [N-1:0]    m_pend;
    bit            m_seen;
    bit            m_busy;
    int            m_id;
    int            m_last;
    bit [TS_W-1:0] m_time;
    bit [TS_W-1:0] m_ts;

    task automatic model_next();
        bit [N-1:0] conf;
        bit [N-1:0] pend_old;
        int g;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                run[i] = 0; m_armed[i] = 1'b1; m_stamp[i] = '0;
            end
            m_pend = '0; m_seen = 1'b0; m_busy = 1'b0; m_id = 0;
            m_last = N - 1; m_time = '0; m_ts = '0;
            return;
        end
        pend_old = m_pend;
        conf = '0;
        for (int i = 0; i < N; i++)
            conf[i] = enable && mon_block[i] && m_armed[i] && (run[i] + 1 == PERSIST);
        if (m_busy) begin
            if (report_ready) begin
                m_pend[m_id] = 1'b0; m_last = m_id; m_busy = 1'b0;
            end
        end else if (pend_old != '0) begin
            g = 0;
            for (int k = 1; k <= N; k++) begin
                g = (m_last + k) % N;
                if (pend_old[g]) break;
            end
            m_busy = 1'b1;
            m_id = g;
`ifdef HLS_DEADLOCK_TIMESTAMP_EN
            m_time = m_stamp[g];
`else
            m_time = '0;
`endif
        end
        for (int i = 0; i < N; i++) begin
            if (conf[i]) begin
                m_pend[i] = 1'b1; m_armed[i] = 1'b0; m_stamp[i] = m_ts;
            end else if (!pend_old[i] && !mon_block[i]) begin
                m_armed[i] = 1'b1;
            end
            run[i] = (enable && mon_block[i]) ? run[i] + 1 : 0;
        end
        if (|conf) m_seen = 1'b1;
        else if (clear_seen) m_seen = 1'b0;
        m_ts = m_ts + 1;
    endtask

    task automatic tick();
        model_next();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; mon_block = '0; report_ready = 1'b0; clear_seen = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", report_valid); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
        checks++; if (deadlock_seen !== 1'b0) begin errors++; $display("FAIL reset_seen: got %b expected 0", deadlock_seen); end
        checks++; if (report_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", report_id); end
        checks++; if (report_time !== 32'd0) begin errors++; $display("FAIL reset_time: got %0d expected 0", report_time); end
    endtask

    task automatic test_single();
        int extra;
        do_reset();
        enable = 1'b1; report_ready = 1'b1; mon_block = 4'b0001;
        for (int c = 0; c < PERSIST - 1; c++) tick();
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_early: got %b expected 0000 at cycle 15", pending); end
        tick();
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL single_pending: got %b expected 0001 at cycle 16", pending); end
        checks++; if (deadlock_seen !== 1'b1) begin errors++; $display("FAIL single_seen: got %b expected 1", deadlock_seen); end
        tick();
        checks++; if (report_valid !== 1'b1 || report_id !== 2'd0) begin errors++; $display("FAIL single_report: valid %b id %0d expected valid 1 id 0", report_valid, report_id); end
        tick();
        checks++; if (report_valid !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL single_done: valid %b pending %b expected 0 0000", report_valid, pending); end
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            if (report_valid === 1'b1) extra++;
            tick();
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL single_no_rereport: got %0d extra valid cycles expected 0", extra); end
    endtask

    task automatic test_glitch();
        do_reset();
        enable = 1'b1; report_ready = 1'b1; mon_block = 4'b0100;
        for (int c = 0; c < PERSIST - 1; c++) tick();
        mon_block = 4'b0000;
        tick();
        checks++; if (pending !== 4'b0000 || report_valid !== 1'b0) begin errors++; $display("FAIL glitch_filtered: pending %b valid %b expected 0000 0", pending, report_valid); end
        mon_block = 4'b0100;
        for (int c = 0; c < PERSIST - 1; c++) tick();
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL glitch_early: got %b expected 0000", pending); end
        tick();
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL glitch_pending: got %b expected 0100", pending); end
        tick();
        checks++; if (report_valid !== 1'b1 || report_id !== 2'd2) begin errors++; $display("FAIL glitch_report: valid %b id %0d expected 1 2", report_valid, report_id); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        enable = 1'b1; report_ready = 1'b1; mon_block = 4'b1111;
        for (int c = 0; c < PERSIST; c++) tick();
        checks++; if (pending !== 4'b1111) begin errors++; $display("FAIL b2b_pending: got %b expected 1111", pending); end
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (report_valid !== ((c % 2) == 0) || (report_valid === 1'b1 && report_id !== ID_W'(c / 2))) begin
                errors++; $display("FAIL b2b_order: step %0d valid %b id %0d expected valid %0d id %0d", c, report_valid, report_id, (c % 2) == 0, c / 2);
            end
        end
        mon_block[1] = 1'b0;
        tick();
        mon_block[1] = 1'b1;
        for (int c = 0; c < PERSIST; c++) tick();
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL b2b_rearm_pending: got %b expected 0010", pending); end
        tick();
        checks++; if (report_valid !== 1'b1 || report_id !== 2'd1) begin errors++; $display("FAIL b2b_rearm_report: valid %b id %0d expected 1 1", report_valid, report_id); end
    endtask

    task automatic test_stall();
        logic [ID_W-1:0] id0;
        logic [TS_W-1:0] t0;
        int bad, xfers;
        do_reset();
        enable = 1'b1; report_ready = 1'b0; mon_block = 4'b0001;
        for (int c = 0; c < PERSIST + 1; c++) tick();
        id0 = report_id; t0 = report_time;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (report_valid !== 1'b1 || report_id !== id0 || report_time !== t0) bad++;
            tick();
        end
        checks++; if (bad !== 0 || id0 !== 2'd0) begin errors++; $display("FAIL stall_stable: %0d unstable cycles id %0d expected 0 unstable id 0", bad, id0); end
        report_ready = 1'b1;
        xfers = 0;
        for (int c = 0; c < 6; c++) begin
            if (report_valid === 1'b1 && report_ready === 1'b1) xfers++;
            tick();
        end
        checks++; if (xfers !== 1) begin errors++; $display("FAIL stall_xfers: got %0d expected 1", xfers); end
    endtask

    task automatic test_reset_mid_report();
        do_reset();
        enable = 1'b1; report_ready = 1'b0; mon_block = 4'b0110;
        for (int c = 0; c < PERSIST + 1; c++) tick();
        checks++; if (report_valid !== 1'b1 || report_id !== 2'd1 || pending !== 4'b0110) begin errors++; $display("FAIL midrst_pre: valid %b id %0d pending %b expected 1 1 0110", report_valid, report_id, pending); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (report_valid !== 1'b0 || pending !== 4'b0000 || deadlock_seen !== 1'b0) begin errors++; $display("FAIL midrst_clear: valid %b pending %b seen %b expected 0 0000 0", report_valid, pending, deadlock_seen); end
        for (int c = 0; c < PERSIST - 1; c++) tick();
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL midrst_early: got %b expected 0000", pending); end
        tick();
        checks++; if (pending !== 4'b0110) begin errors++; $display("FAIL midrst_reconfirm: got %b expected 0110", pending); end
    endtask

    task automatic test_timestamp_clear();
        logic [TS_W-1:0] exp_t;
        do_reset();
        enable = 1'b1; report_ready = 1'b1;
        for (int c = 0; c < 100; c++) tick();
        mon_block = 4'b1000;
        for (int c = 0; c < PERSIST + 1; c++) tick();
`ifdef HLS_DEADLOCK_TIMESTAMP_EN
        exp_t = 32'd115;
`else
        exp_t = 32'd0;
`endif
        checks++; if (report_valid !== 1'b1 || report_id !== 2'd3 || report_time !== exp_t) begin errors++; $display("FAIL ts_report: valid %b id %0d time %0d expected 1 3 %0d", report_valid, report_id, report_time, exp_t); end
        tick();
        clear_seen = 1'b1;
        tick();
        clear_seen = 1'b0;
        checks++; if (deadlock_seen !== 1'b0) begin errors++; $display("FAIL clear_alone: got %b expected 0", deadlock_seen); end
        mon_block[0] = 1'b1;
        for (int c = 0; c < PERSIST - 1; c++) tick();
        clear_seen = 1'b1;
        tick();
        clear_seen = 1'b0;
        checks++; if (deadlock_seen !== 1'b1 || pending[0] !== 1'b1) begin errors++; $display("FAIL clear_set_wins: seen %b pending %b expected 1 xxx1", deadlock_seen, pending); end
    endtask

    task automatic test_random();
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 3000 && errors < 40; c++) begin
            checks++; if (report_valid !== m_busy) begin errors++; $display("FAIL rand_valid: cycle %0d got %b expected %b", c, report_valid, m_busy); end
            checks++; if (pending !== m_pend) begin errors++; $display("FAIL rand_pending: cycle %0d got %b expected %b", c, pending, m_pend); end
            checks++; if (deadlock_seen !== m_seen) begin errors++; $display("FAIL rand_seen: cycle %0d got %b expected %b", c, deadlock_seen, m_seen); end
            if (m_busy) begin
                checks++; if (report_id !== ID_W'(m_id) || report_time !== m_time) begin errors++; $display("FAIL rand_report: cycle %0d id %0d time %0d expected %0d %0d", c, report_id, report_time, m_id, m_time); end
            end
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 19) == 0) mon_block[i] = ~mon_block[i];
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            report_ready = ($urandom_range(0, 2) != 0);
            clear_seen = ($urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0; clear_seen = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_back_to_back();
        test_stall();
        test_reset_mid_report();
        test_timestamp_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
